// File: rtl/fp24_from_fixed.sv
// Iterative signed fixed-point to fp24 converter with a runtime power-of-two scale.
// Normalizes one bit per cycle; valid/ready handshakes on input and output.
module fp24_from_fixed #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_data,
    output logic             out_overflow,
    output logic             out_underflow
);

    // Handshake: a transfer happens on a rising clk edge where valid and ready
    // are both high; the producer holds its payload stable until then.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [10:0] EXP_BASE = 11'(WIDTH - 1 - FRAC_BITS + 63);

    state_t            state;
    state_t            state_next;
    logic              sign_q;
    logic [WIDTH-1:0]  mag_q;
    logic [WIDTH-1:0]  mag_in;
    logic [7:0]        scale_q;
    logic [5:0]        lz_q;
    logic              take;
    logic              norm_done;
    logic signed [10:0] exp_calc;
    logic [15:0]       mant;

    // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign mag_in    = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
    assign take      = in_valid && in_ready;
    assign norm_done = (state == NORM) && mag_q[WIDTH-1];
    assign exp_calc  = EXP_BASE - $signed({5'b0, lz_q}) + $signed({{3{scale_q[7]}}, scale_q});
    assign mant      = mag_q[WIDTH-2 -: 16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (take) state_next = (mag_in == '0) ? DONE : NORM;
            NORM: if (mag_q[WIDTH-1]) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q  <= 1'b0;
            mag_q   <= '0;
            scale_q <= '0;
            lz_q    <= '0;
        end else if (take) begin
            sign_q  <= in_data[WIDTH-1];
            mag_q   <= mag_in;
            scale_q <= in_scale;
            lz_q    <= '0;
        end else if ((state == NORM) && !mag_q[WIDTH-1]) begin
            mag_q <= mag_q << 1;
            lz_q  <= lz_q + 6'd1;
        end
    end

    // Result registers stay put through DONE so the output is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= 24'h000000;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (take && (mag_in == '0)) begin
            out_data      <= 24'h000000;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (norm_done) begin
            if (exp_calc > 11'sd127) begin
                out_data      <= {sign_q, 7'h7F, 16'hFFFF};
                out_overflow  <= 1'b1;
                out_underflow <= 1'b0;
            end else if (exp_calc < 11'sd1) begin
                out_data      <= 24'h000000;
                out_overflow  <= 1'b0;
                out_underflow <= 1'b1;
            end else begin
                out_data      <= {sign_q, exp_calc[6:0], mant};
                out_overflow  <= 1'b0;
                out_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp24_from_fixed.sv
// Bench for fp24_from_fixed: arithmetic reference model, per-cycle compare of
// handshake signals and results, directed cases plus randomized traffic.
module tb_fp24_from_fixed;

    localparam int WIDTH     = 32;
    localparam int FRAC_BITS = 0;

    typedef struct packed {
        logic [31:0] due;
        logic        ovf;
        logic        unf;
        logic [23:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [7:0]  in_scale = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic        out_overflow;
    logic        out_underflow;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_val = 1'b1;
    exp_t exp_q[$];

    fp24_from_fixed #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_scale(in_scale),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        else          out_ready = rdy_val;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Value = d * 2^(scale - FRAC_BITS); find the leading one with plain arithmetic.
    function automatic exp_t model(input logic [31:0] d, input logic [7:0] s);
        exp_t   r;
        longint v, mag;
        int     p, e;
        v   = longint'($signed(d));
        mag = (v < 0) ? -v : v;
        r   = '0;
        if (mag == 0) begin
            r.due = 32'd1;
            return r;
        end
        p = 0;
        for (int i = 0; i < WIDTH; i++) if (((mag >> i) & 1) == 1) p = i;
        e = p - FRAC_BITS + int'($signed(s)) + 63;
        r.due = 32'(2 + (WIDTH - 1 - p));
        if (e > 127) begin
            r.data = {d[31], 23'h7FFFFF};
            r.ovf  = 1'b1;
        end else if (e < 1) begin
            r.unf = 1'b1;
        end else begin
            r.data = {d[31], 7'(e), 16'((((mag << 16) >> p)) & 64'hFFFF)};
        end
        return r;
    endfunction

    task automatic pin(input logic [31:0] d, input logic [7:0] s, input logic [23:0] want,
                       input logic ovf, input logic unf, input int lat);
        exp_t m;
        m = model(d, s);
        chk("pin_data", 32'(m.data), 32'(want));
        chk("pin_flags", {30'd0, m.ovf, m.unf}, {30'd0, ovf, unf});
        chk("pin_latency", m.due, 32'(lat));
    endtask

    // Monitor: in_ready, out_valid and the result are compared every cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_rdy;
        bit   exp_v;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        end else begin
            exp_rdy = (exp_q.size() == 0);
            exp_v   = !exp_rdy && (cyc >= int'(exp_q[0].due));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v && out_valid) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                chk("out_flags", {30'd0, out_overflow, out_underflow},
                    {30'd0, exp_q[0].ovf, exp_q[0].unf});
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                e = model(in_data, in_scale);
                e.due = e.due + 32'(cyc);
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [7:0] s);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_scale = s;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic directed(input logic [31:0] d, input logic [7:0] s, input logic [23:0] want,
                            input logic ovf, input logic unf, input int lat);
        pin(d, s, want, ovf, unf, lat);
        send(d, s);
        drain();
    endtask

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  s;
        int          n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        directed(32'd1, 8'd0, 24'h3F0000, 1'b0, 1'b0, 33);
        directed(-32'sd6, 8'd0, 24'hC18000, 1'b0, 1'b0, 31);
        directed(32'h80000000, 8'd0, 24'hDE0000, 1'b0, 1'b0, 2);
        directed(32'd0, 8'd0, 24'h000000, 1'b0, 1'b0, 1);
        directed(32'h0001FFFF, 8'd0, 24'h4FFFFF, 1'b0, 1'b0, 17);
        directed(32'h0003FFFF, 8'd0, 24'h50FFFF, 1'b0, 1'b0, 16);
        directed(32'h40000000, 8'd100, 24'h7FFFFF, 1'b1, 1'b0, 3);
        directed(32'd1, 8'hBA, 24'h000000, 1'b0, 1'b1, 33);

        // Backpressure with ignored input pulses while busy.
        rdy_val = 1'b0;
        send(32'd5, 8'd3);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            in_scale = 8'($urandom);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        rdy_val = 1'b1;
        drain();

        // Reset in the middle of normalization.
        send(32'd1, 8'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        directed(32'd1, 8'd0, 24'h3F0000, 1'b0, 1'b0, 33);

        // Randomized traffic with random output backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: d = $urandom;
                1: d = 32'($urandom_range(0, 15)) * (($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd1);
                2: d = 32'd0;
                3: d = 32'd1 << $urandom_range(0, 31);
                4: d = $urandom >> $urandom_range(0, 31);
                default: d = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'hFFFFFFFF;
            endcase
            if ($urandom_range(0, 3) == 0) s = 8'($urandom);
            else                           s = 8'($urandom_range(0, 40) - 20);
            send(d, s);
        end
        drain();
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
